qracc_macro_seq: RTL and testbench

- Digital sequencer that drives the analog_inputs_t bundle of the QR accelerator CIM macro and consumes its analog_outputs_t bundle.
- Turns three request types into timed macro phase sequences: row write, row read (sense-amp), and analog MAC compute.
- Returns SA_OUT read data and thermometer-decoded ADC results to the digital core.
- Sits between the qracc core controller and the analog macro.

---
 rtl/qracc_macro_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_qracc_macro_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qracc_macro_seq.sv
// qracc_macro_seq: sequences row write, row read and analog MAC compute
// phases for the QR accelerator CIM macro and returns SA / ADC results.
//
// state        | meaning
// -------------+----------------------------------------------------
// S_IDLE       | rows parked on VRST, waiting for a request
// S_WR_PCH     | write: bitline precharge (tPch)
// S_WR_WL      | write: wordline + write drivers on (tWl)
// S_RD_PCH     | read: bitline precharge (tPch)
// S_RD_WL      | read: wordline on, bitlines develop (tWl)
// S_RD_SA      | read: sense amp fires, SA_OUT captured (1)
// S_CMP_RST    | compute: rows held on VRST, R2A closed (1)
// S_CMP_DRIVE  | compute: rows driven to VDR/VSS from cmp_in (tWl)
// S_CMP_M2A    | compute: M2A charge transfer (1)
// S_CMP_CONV   | compute: ADC conversion, CLK on first cycle (tConv)
// S_CMP_CAPT   | compute: ADC_OUT captured and decoded (1)
// S_RESULT     | result presented until consumed

package qracc_pkg;
    // Macro geometry; the sequencer size parameters must match these.
    localparam int NUM_ROWS   = 128;
    localparam int NUM_COLS   = 32;
    localparam int COMP_COUNT = 15;

    typedef struct packed {
        logic [NUM_ROWS-1:0] VRST_SEL;
        logic [NUM_ROWS-1:0] VRST_SELB;
        logic [NUM_ROWS-1:0] VDR_SEL;
        logic [NUM_ROWS-1:0] VDR_SELB;
        logic [NUM_ROWS-1:0] VSS_SEL;
        logic [NUM_ROWS-1:0] VSS_SELB;
        logic [NUM_ROWS-1:0] WL;
        logic [NUM_ROWS-1:0] WLB;
        logic                PCH;
        logic                PCHB;
        logic                WRITE;
        logic                WRITEB;
        logic [NUM_COLS-1:0] CSEL;
        logic [NUM_COLS-1:0] CSELB;
        logic                SAEN;
        logic                SAENB;
        logic [NUM_COLS-1:0] WR_DATA;
        logic [NUM_COLS-1:0] WR_DATAB;
        logic                R2A;
        logic                R2AB;
        logic                M2A;
        logic                M2AB;
        logic                NF;
        logic                NFB;
        logic                CLK;
        logic                CLKB;
    } analog_inputs_t;

    typedef struct packed {
        logic [NUM_COLS-1:0]            SA_OUT;
        logic [NUM_COLS*COMP_COUNT-1:0] ADC_OUT;
    } analog_outputs_t;
endpackage

module qracc_macro_seq
    import qracc_pkg::*;
#(
    parameter int numRows   = NUM_ROWS,
    parameter int numCols   = NUM_COLS,
    parameter int compCount = COMP_COUNT,
    parameter int adcBits   = $clog2(compCount + 1),
    parameter int tPch      = 2,
    parameter int tWl       = 2,
    parameter int tConv     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(numRows)-1:0]   wr_addr,
    input  logic [numCols-1:0]           wr_data,
    input  logic                         rd_valid,
    output logic                         rd_ready,
    input  logic [$clog2(numRows)-1:0]   rd_addr,
    input  logic                         cmp_valid,
    output logic                         cmp_ready,
    input  logic [numRows-1:0]           cmp_in,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         res_is_cmp,
    output logic [numCols*adcBits-1:0]   res_data,
    output analog_inputs_t               to_analog,
    input  analog_outputs_t              from_analog
);
    localparam int AW = $clog2(numRows);
    localparam int RW = numCols * adcBits;
    localparam int CW = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PCH, S_WR_WL, S_RD_PCH, S_RD_WL, S_RD_SA,
        S_CMP_RST, S_CMP_DRIVE, S_CMP_M2A, S_CMP_CONV, S_CMP_CAPT, S_RESULT
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               phase_done;
    logic               idle;
    logic               wr_acc, rd_acc, cmp_acc;
    logic [AW-1:0]      addr_q;
    logic [numCols-1:0] data_q;
    logic [numRows-1:0] cmp_q;
    logic [numRows-1:0] wl_onehot;
    logic [RW-1:0]      res_data_q;
    logic               res_is_cmp_q;
    logic [RW-1:0]      adc_dec;
    analog_inputs_t     ai;

    function automatic logic [CW-1:0] phase_len(input state_t s);
        case (s)
            S_WR_PCH, S_RD_PCH:            phase_len = CW'(tPch);
            S_WR_WL, S_RD_WL, S_CMP_DRIVE: phase_len = CW'(tWl);
            S_CMP_CONV:                    phase_len = CW'(tConv);
            default:                       phase_len = CW'(1);
        endcase
    endfunction

    // Bubble-tolerant thermometer decode: count the ones.
    function automatic logic [adcBits-1:0] popcnt(input logic [compCount-1:0] v);
        logic [adcBits-1:0] s;
        s = '0;
        for (int i = 0; i < compCount; i++) s = s + adcBits'(v[i]);
        return s;
    endfunction

    assign phase_done = (cnt_q == '0);
    assign idle       = (state_q == S_IDLE) && !rst;
    assign wr_acc     = wr_valid && wr_ready;
    assign rd_acc     = rd_valid && rd_ready;
    assign cmp_acc    = cmp_valid && cmp_ready;
    assign wl_onehot  = {{(numRows-1){1'b0}}, 1'b1} << addr_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Phase down-counter, reloaded on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt_q <= '0;
        else if (state_d != state_q) cnt_q <= phase_len(state_d) - CW'(1);
        else if (!phase_done)        cnt_q <= cnt_q - CW'(1);
    end

    // Request arbitration (write > read > compute) and next-state logic.
    always_comb begin
        state_d   = state_q;
        wr_ready  = idle;
        rd_ready  = idle && !wr_valid;
        cmp_ready = idle && !wr_valid && !rd_valid;
        case (state_q)
            S_IDLE: begin
                if (wr_acc)       state_d = S_WR_PCH;
                else if (rd_acc)  state_d = S_RD_PCH;
                else if (cmp_acc) state_d = S_CMP_RST;
            end
            S_WR_PCH:    if (phase_done) state_d = S_WR_WL;
            S_WR_WL:     if (phase_done) state_d = S_IDLE;
            S_RD_PCH:    if (phase_done) state_d = S_RD_WL;
            S_RD_WL:     if (phase_done) state_d = S_RD_SA;
            S_RD_SA:     if (phase_done) state_d = S_RESULT;
            S_CMP_RST:   if (phase_done) state_d = S_CMP_DRIVE;
            S_CMP_DRIVE: if (phase_done) state_d = S_CMP_M2A;
            S_CMP_M2A:   if (phase_done) state_d = S_CMP_CONV;
            S_CMP_CONV:  if (phase_done) state_d = S_CMP_CAPT;
            S_CMP_CAPT:  if (phase_done) state_d = S_RESULT;
            S_RESULT:    if (res_ready)  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Request payload capture on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            cmp_q  <= '0;
        end else begin
            if (wr_acc) begin
                addr_q <= wr_addr;
                data_q <= wr_data;
            end else if (rd_acc) begin
                addr_q <= rd_addr;
            end
            if (cmp_acc) cmp_q <= cmp_in;
        end
    end

    // Per-column ADC decode.
    always_comb begin
        adc_dec = '0;
        for (int c = 0; c < numCols; c++)
            adc_dec[c*adcBits +: adcBits] = popcnt(from_analog.ADC_OUT[c*compCount +: compCount]);
    end

    // Result capture at the end of the sense / capture phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data_q   <= '0;
            res_is_cmp_q <= 1'b0;
        end else if (state_q == S_RD_SA) begin
            res_data_q   <= RW'(from_analog.SA_OUT);
            res_is_cmp_q <= 1'b0;
        end else if (state_q == S_CMP_CAPT) begin
            res_data_q   <= adc_dec;
            res_is_cmp_q <= 1'b1;
        end
    end

    assign res_valid  = (state_q == S_RESULT);
    assign res_data   = res_valid ? res_data_q : '0;
    assign res_is_cmp = res_valid && res_is_cmp_q;

    // Macro control decode; rows stay driven from CMP_DRIVE through CMP_CAPT.
    always_comb begin
        ai          = '0;
        ai.VRST_SEL = '1;
        ai.R2A      = 1'b1;
        case (state_q)
            S_WR_PCH, S_RD_PCH: ai.PCH = 1'b1;
            S_WR_WL: begin
                ai.WL      = wl_onehot;
                ai.WRITE   = 1'b1;
                ai.WR_DATA = data_q;
                ai.CSEL    = '1;
            end
            S_RD_WL: begin
                ai.WL   = wl_onehot;
                ai.CSEL = '1;
            end
            S_RD_SA: begin
                ai.WL   = wl_onehot;
                ai.CSEL = '1;
                ai.SAEN = 1'b1;
            end
            S_CMP_DRIVE, S_CMP_M2A, S_CMP_CONV, S_CMP_CAPT: begin
                ai.VRST_SEL = '0;
                ai.VDR_SEL  = cmp_q;
                ai.VSS_SEL  = ~cmp_q;
                ai.R2A      = 1'b0;
                ai.M2A      = (state_q == S_CMP_M2A);
                ai.NF       = (state_q == S_CMP_CONV);
                ai.CLK      = (state_q == S_CMP_CONV) && (cnt_q == CW'(tConv - 1));
            end
            default: ;
        endcase
        ai.VRST_SELB = ~ai.VRST_SEL;
        ai.VDR_SELB  = ~ai.VDR_SEL;
        ai.VSS_SELB  = ~ai.VSS_SEL;
        ai.WLB       = ~ai.WL;
        ai.PCHB      = ~ai.PCH;
        ai.WRITEB    = ~ai.WRITE;
        ai.CSELB     = ~ai.CSEL;
        ai.SAENB     = ~ai.SAEN;
        ai.WR_DATAB  = ~ai.WR_DATA;
        ai.R2AB      = ~ai.R2A;
        ai.M2AB      = ~ai.M2A;
        ai.NFB       = ~ai.NF;
        ai.CLKB      = ~ai.CLK;
    end

    assign to_analog = ai;

endmodule

// File: tb/tb_qracc_macro_seq.sv
// Self-checking bench for qracc_macro_seq: directed scenarios plus random
// request mixes compared against a phase-list reference model.
module tb_qracc_macro_seq;
    import qracc_pkg::*;

    localparam int ROWS = 128, COLS = 32, CC = 15, AB = 4;
    localparam int T_PCH = 2, T_WL = 2, T_CONV = 3;
    localparam int AW = 7, RW = COLS * AB;

    logic            clk, rst;
    logic            wr_valid, wr_ready, rd_valid, rd_ready, cmp_valid, cmp_ready;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic [COLS-1:0] wr_data;
    logic [ROWS-1:0] cmp_in;
    logic            res_valid, res_ready, res_is_cmp;
    logic [RW-1:0]   res_data;
    analog_inputs_t  to_analog;
    analog_outputs_t from_analog;

    qracc_macro_seq #(
        .numRows(ROWS), .numCols(COLS), .compCount(CC), .adcBits(AB),
        .tPch(T_PCH), .tWl(T_WL), .tConv(T_CONV)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_in(cmp_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_is_cmp(res_is_cmp),
        .res_data(res_data), .to_analog(to_analog), .from_analog(from_analog)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit freeze = 1'b0;
    analog_inputs_t exp_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic analog_inputs_t idle_b();
        analog_inputs_t r;
        r = '0;
        r.VRST_SEL = '1;
        r.R2A = 1'b1;
        return r;
    endfunction

    function automatic analog_inputs_t with_b(input analog_inputs_t e);
        analog_inputs_t r;
        r = e;
        r.VRST_SELB = ~e.VRST_SEL;  r.VDR_SELB = ~e.VDR_SEL;  r.VSS_SELB = ~e.VSS_SEL;
        r.WLB = ~e.WL;  r.PCHB = ~e.PCH;  r.WRITEB = ~e.WRITE;  r.CSELB = ~e.CSEL;
        r.SAENB = ~e.SAEN;  r.WR_DATAB = ~e.WR_DATA;  r.R2AB = ~e.R2A;
        r.M2AB = ~e.M2A;  r.NFB = ~e.NF;  r.CLKB = ~e.CLK;
        return r;
    endfunction

    task automatic check_bundle(input string tag, input analog_inputs_t e);
        analog_inputs_t x;
        x = with_b(e);
        chk({tag, ".vrst"},   128'(to_analog.VRST_SEL),  128'(x.VRST_SEL));
        chk({tag, ".vrstb"},  128'(to_analog.VRST_SELB), 128'(x.VRST_SELB));
        chk({tag, ".vdr"},    128'(to_analog.VDR_SEL),   128'(x.VDR_SEL));
        chk({tag, ".vdrb"},   128'(to_analog.VDR_SELB),  128'(x.VDR_SELB));
        chk({tag, ".vss"},    128'(to_analog.VSS_SEL),   128'(x.VSS_SEL));
        chk({tag, ".vssb"},   128'(to_analog.VSS_SELB),  128'(x.VSS_SELB));
        chk({tag, ".wl"},     128'(to_analog.WL),        128'(x.WL));
        chk({tag, ".wlb"},    128'(to_analog.WLB),       128'(x.WLB));
        chk({tag, ".pch"},    128'(to_analog.PCH),       128'(x.PCH));
        chk({tag, ".pchb"},   128'(to_analog.PCHB),      128'(x.PCHB));
        chk({tag, ".write"},  128'(to_analog.WRITE),     128'(x.WRITE));
        chk({tag, ".writeb"}, 128'(to_analog.WRITEB),    128'(x.WRITEB));
        chk({tag, ".csel"},   128'(to_analog.CSEL),      128'(x.CSEL));
        chk({tag, ".cselb"},  128'(to_analog.CSELB),     128'(x.CSELB));
        chk({tag, ".saen"},   128'(to_analog.SAEN),      128'(x.SAEN));
        chk({tag, ".saenb"},  128'(to_analog.SAENB),     128'(x.SAENB));
        chk({tag, ".wdat"},   128'(to_analog.WR_DATA),   128'(x.WR_DATA));
        chk({tag, ".wdatb"},  128'(to_analog.WR_DATAB),  128'(x.WR_DATAB));
        chk({tag, ".r2a"},    128'(to_analog.R2A),       128'(x.R2A));
        chk({tag, ".r2ab"},   128'(to_analog.R2AB),      128'(x.R2AB));
        chk({tag, ".m2a"},    128'(to_analog.M2A),       128'(x.M2A));
        chk({tag, ".m2ab"},   128'(to_analog.M2AB),      128'(x.M2AB));
        chk({tag, ".nf"},     128'(to_analog.NF),        128'(x.NF));
        chk({tag, ".nfb"},    128'(to_analog.NFB),       128'(x.NFB));
        chk({tag, ".clk"},    128'(to_analog.CLK),       128'(x.CLK));
        chk({tag, ".clkb"},   128'(to_analog.CLKB),      128'(x.CLKB));
    endtask

    task automatic check_readies_low(input string tag);
        chk({tag, ".wr_ready"},  128'(wr_ready),  128'(0));
        chk({tag, ".rd_ready"},  128'(rd_ready),  128'(0));
        chk({tag, ".cmp_ready"}, 128'(cmp_ready), 128'(0));
    endtask

    // Reference phase lists: one expected bundle per cycle of the sequence.
    function automatic void build_write(input logic [AW-1:0] a, input logic [COLS-1:0] d);
        analog_inputs_t r;
        exp_q = {};
        for (int i = 0; i < T_PCH; i++) begin r = idle_b(); r.PCH = 1'b1; exp_q.push_back(r); end
        for (int i = 0; i < T_WL; i++) begin
            r = idle_b(); r.WL = ROWS'(1) << a; r.WRITE = 1'b1; r.WR_DATA = d; r.CSEL = '1;
            exp_q.push_back(r);
        end
    endfunction

    function automatic void build_read(input logic [AW-1:0] a);
        analog_inputs_t r;
        exp_q = {};
        for (int i = 0; i < T_PCH; i++) begin r = idle_b(); r.PCH = 1'b1; exp_q.push_back(r); end
        for (int i = 0; i <= T_WL; i++) begin
            r = idle_b(); r.WL = ROWS'(1) << a; r.CSEL = '1; r.SAEN = (i == T_WL);
            exp_q.push_back(r);
        end
    endfunction

    function automatic void build_cmp(input logic [ROWS-1:0] x);
        analog_inputs_t d, r;
        exp_q = {};
        exp_q.push_back(idle_b());
        d = idle_b(); d.VRST_SEL = '0; d.VDR_SEL = x; d.VSS_SEL = ~x; d.R2A = 1'b0;
        for (int i = 0; i < T_WL; i++) exp_q.push_back(d);
        r = d; r.M2A = 1'b1; exp_q.push_back(r);
        for (int i = 0; i < T_CONV; i++) begin r = d; r.NF = 1'b1; r.CLK = (i == 0); exp_q.push_back(r); end
        exp_q.push_back(d);
    endfunction

    function automatic logic [127:0] adc_ref(input analog_outputs_t a);
        logic [127:0] r;
        logic [CC-1:0] col;
        r = '0;
        for (int c = 0; c < COLS; c++) begin
            col = a.ADC_OUT[c*CC +: CC];
            r[c*AB +: AB] = AB'($countones(col));
        end
        return r;
    endfunction

    task automatic rand_analog();
        logic [CC-1:0] col;
        from_analog.SA_OUT = $urandom;
        for (int c = 0; c < COLS; c++) begin
            case ($urandom_range(0, 3))
                0:       col = '1;
                1:       col = '0;
                default: col = CC'($urandom);
            endcase
            from_analog.ADC_OUT[c*CC +: CC] = col;
        end
    endtask

    task automatic issue(input bit wv, input bit rv, input bit cv, output int w);
        wr_valid = wv; rd_valid = rv; cmp_valid = cv;
        res_ready = 1'($urandom_range(0, 1));
        #1;
        chk("issue.wr_ready",  128'(wr_ready),  128'(1));
        chk("issue.rd_ready",  128'(rd_ready),  128'(!wv));
        chk("issue.cmp_ready", 128'(cmp_ready), 128'(!wv && !rv));
        w = wv ? 0 : (rv ? 1 : 2);
    endtask

    task automatic run_seq(input int w, output logic [127:0] ed, output bit ic);
        analog_outputs_t cap;
        ic = (w == 2);
        case (w)
            0:       build_write(wr_addr, wr_data);
            1:       build_read(rd_addr);
            default: build_cmp(cmp_in);
        endcase
        cap = from_analog;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                res_ready = 1'b0;
                case (w)
                    0:       wr_valid = 1'b0;
                    1:       rd_valid = 1'b0;
                    default: cmp_valid = 1'b0;
                endcase
            end
            case (w)
                0:       begin wr_addr = AW'($urandom); wr_data = $urandom; end
                1:       rd_addr = AW'($urandom);
                default: cmp_in = {$urandom, $urandom, $urandom, $urandom};
            endcase
            if (!freeze) rand_analog();
            cap = from_analog;
            check_bundle($sformatf("seq%0d.c%0d", w, i), exp_q[i]);
            check_readies_low($sformatf("seq%0d.c%0d", w, i));
            chk($sformatf("seq%0d.c%0d.res_valid", w, i), 128'(res_valid), 128'(0));
        end
        ed = ic ? adc_ref(cap) : 128'(cap.SA_OUT);
    endtask

    task automatic finish_result(input bit ic, input logic [127:0] ed, input int hold);
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            chk("res.valid",  128'(res_valid),  128'(1));
            chk("res.is_cmp", 128'(res_is_cmp), 128'(ic));
            chk("res.data",   128'(res_data),   ed);
            check_readies_low("res");
            check_bundle("res", idle_b());
            rand_analog();
            if (i == hold) res_ready = 1'b1;
        end
        @(negedge clk);
        res_ready = 1'b0;
        chk("post.res_valid", 128'(res_valid), 128'(0));
        check_bundle("post", idle_b());
    endtask

    task automatic do_txn(input bit wv, input bit rv, input bit cv, input int hold);
        int w;
        logic [127:0] ed;
        bit ic;
        issue(wv, rv, cv, w);
        run_seq(w, ed, ic);
        if (w == 0) begin
            @(negedge clk);
            chk("wr.done.res_valid", 128'(res_valid), 128'(0));
            check_bundle("wr.done", idle_b());
        end else begin
            finish_result(ic, ed, hold);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [127:0] ed;
        bit ic;
        logic [2:0] r;

        rst = 1'b1; wr_valid = 0; rd_valid = 0; cmp_valid = 0; res_ready = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; cmp_in = '0; from_analog = '0;
        repeat (2) @(negedge clk);
        check_bundle("rst", idle_b());
        check_readies_low("rst");
        chk("rst.res_valid", 128'(res_valid), 128'(0));
        chk("rst.res_data",  128'(res_data),  128'(0));
        rst = 1'b0;

        // Directed write
        wr_addr = 7'd5; wr_data = 32'hA5A5A5A5;
        do_txn(1, 0, 0, 0);

        // Directed read with held result
        freeze = 1'b1;
        rd_addr = 7'd5; from_analog.SA_OUT = 32'hA5A5A5A5;
        do_txn(0, 1, 0, 3);

        // Directed compute with bubble column
        cmp_in = 128'h0F;
        from_analog.ADC_OUT = '0;
        from_analog.ADC_OUT[0 +: CC]    = 15'h7FFF;
        from_analog.ADC_OUT[CC +: CC]   = 15'h0000;
        from_analog.ADC_OUT[2*CC +: CC] = 15'h00FB;
        issue(0, 0, 1, w);
        run_seq(w, ed, ic);
        @(negedge clk);
        chk("cmp.col0", 128'(res_data[0 +: AB]),    128'(15));
        chk("cmp.col1", 128'(res_data[AB +: AB]),   128'(0));
        chk("cmp.col2", 128'(res_data[2*AB +: AB]), 128'(7));
        finish_result(ic, ed, 1);
        freeze = 1'b0;

        // Simultaneous requests: write, then read, then compute
        wr_addr = AW'($urandom); wr_data = $urandom; rd_addr = AW'($urandom);
        cmp_in = {$urandom, $urandom, $urandom, $urandom};
        do_txn(1, 1, 1, 0);
        do_txn(0, 1, 1, 2);
        do_txn(0, 0, 1, 1);

        // Reset in the middle of CMP_DRIVE
        cmp_in = {$urandom, $urandom, $urandom, $urandom};
        issue(0, 0, 1, w);
        build_cmp(cmp_in);
        @(negedge clk);
        cmp_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        check_bundle("drive", exp_q[1]);
        rst = 1'b1;
        #1;
        check_bundle("midrst", idle_b());
        check_readies_low("midrst");
        chk("midrst.res_valid", 128'(res_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("relrst.rd_ready", 128'(rd_ready), 128'(1));

        // Reset while a read result is pending drops it
        rd_addr = AW'($urandom);
        issue(0, 1, 0, w);
        run_seq(w, ed, ic);
        @(negedge clk);
        chk("pend.res_valid", 128'(res_valid), 128'(1));
        rst = 1'b1;
        #1;
        chk("pendrst.res_valid", 128'(res_valid), 128'(0));
        chk("pendrst.res_data",  128'(res_data),  128'(0));
        check_bundle("pendrst", idle_b());
        @(negedge clk);
        rst = 1'b0;

        // Random request mixes
        for (int n = 0; n < 60; n++) begin
            r = 3'($urandom_range(1, 7));
            wr_addr = AW'($urandom); wr_data = $urandom; rd_addr = AW'($urandom);
            cmp_in = {$urandom, $urandom, $urandom, $urandom};
            rand_analog();
            do_txn(r[0], r[1], r[2], $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
